// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC/nPC pair with one-slot delayed branching, a
//   byte-wide instruction memory with a preload port, and a retired-fetch counter.
// Latency: Instr is combinational from the registered PC; a taken branch reaches
//   PC two advancing edges later.
// Backpressure: LE=0 freezes PC/nPC/Fetch_Count. A branch resolved during the
//   stall is parked in a pending latch and applied on the next advance.
//
// Ports
//   Clk, Reset      : clock and synchronous active-high reset
//   LE              : advance enable shared with the IF/ID register (0 = stall)
//   Branch_Taken    : taken branch/jump from ID, target on Branch_Target
//   Load_En/Addr/Data : byte preload into instruction memory (ignores Reset/LE)
//   Instr, PC       : big-endian word at PC and the PC itself, to IF/ID
//   nPC             : next fetch address
//   Fetch_Valid     : low only for the first cycle out of reset
//   Branch_Pending  : a taken branch is parked waiting for the stall to release
//   Fetch_Count     : number of advancing cycles since reset (wraps)
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 512,
    parameter int          IMEM_AW    = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LE,
    input  logic               Branch_Taken,
    input  logic [31:0]        Branch_Target,
    input  logic               Load_En,
    input  logic [IMEM_AW-1:0] Load_Addr,
    input  logic [7:0]         Load_Data,
    output logic [31:0]        Instr,
    output logic [31:0]        PC,
    output logic [31:0]        nPC,
    output logic               Fetch_Valid,
    output logic               Branch_Pending,
    output logic [31:0]        Fetch_Count
);

    // ------------------------------------------------------------------
    // Instruction memory
    // ------------------------------------------------------------------
    logic [7:0] mem [IMEM_BYTES];

    // Preload is independent of Reset so a program can be written while the
    // pipeline is held in reset, and contents survive a reset.
    always_ff @(posedge Clk) begin
        if (Load_En) begin
            mem[Load_Addr] <= Load_Data;
        end
    end

    // Word-aligned big-endian read. PC[1:0] and the bits above the memory
    // range are dropped, so the memory aliases every IMEM_BYTES bytes. The
    // byte lanes only differ in the two low bits, so no carry is needed.
    logic [IMEM_AW-3:0] word_idx;
    logic [IMEM_AW-1:0] addr_b0;
    logic [IMEM_AW-1:0] addr_b1;
    logic [IMEM_AW-1:0] addr_b2;
    logic [IMEM_AW-1:0] addr_b3;

    assign word_idx = PC[IMEM_AW-1:2];
    assign addr_b0  = {word_idx, 2'b00};
    assign addr_b1  = {word_idx, 2'b01};
    assign addr_b2  = {word_idx, 2'b10};
    assign addr_b3  = {word_idx, 2'b11};

    assign Instr = {mem[addr_b0], mem[addr_b1], mem[addr_b2], mem[addr_b3]};

    // Address bits that the aliasing memory deliberately ignores.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, PC[31:IMEM_AW], PC[1:0]};

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        eff_taken;
    logic [31:0] eff_target;
    logic [31:0] seq_npc;
    logic [31:0] npc_next;

    // A fresh request from ID always beats a parked one: the parked branch
    // belongs to an instruction that ID has since replaced.
    assign eff_taken  = Branch_Taken | pend_valid;
    assign eff_target = Branch_Taken ? Branch_Target : pend_target;

    // 32-bit modulo arithmetic: FFFF_FFFC + 4 wraps to 0.
    assign seq_npc  = nPC + 32'd4;

    // Delayed branch: PC always takes the old nPC (the delay slot); only the
    // instruction after the slot is redirected.
    assign npc_next = eff_taken ? eff_target : seq_npc;

    assign Branch_Pending = pend_valid;

    // ------------------------------------------------------------------
    // PC / pending / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC          <= RESET_PC;
            nPC         <= RESET_PC + 32'd4;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0000_0000;
            Fetch_Valid <= 1'b0;
            Fetch_Count <= 32'h0000_0000;
        end else begin
            Fetch_Valid <= 1'b1;
            if (LE) begin
                PC          <= nPC;
                nPC         <= npc_next;
                pend_valid  <= 1'b0;
                Fetch_Count <= Fetch_Count + 32'd1;
            end else if (Branch_Taken) begin
                // Park the branch; a later request in the same stall
                // overwrites it.
                pend_valid  <= 1'b1;
                pend_target <= Branch_Target;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios followed by random traffic,
//   every cycle compared against a behavioural model of the fetch rules.
// Inputs driven 1 time unit after posedge, outputs sampled 1 unit after posedge.
module tb_if_fetch_stage;

    localparam int MEMB = 512;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LE;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Load_En;
    logic [8:0]  Load_Addr;
    logic [7:0]  Load_Data;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] nPC;
    logic        Fetch_Valid;
    logic        Branch_Pending;
    logic [31:0] Fetch_Count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0]  m_mem [MEMB];
    logic [31:0] m_pc, m_npc, m_pt, m_cnt;
    logic        m_pv, m_fv;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(512),
        .IMEM_AW   (9)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .LE            (LE),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Load_En       (Load_En),
        .Load_Addr     (Load_Addr),
        .Load_Data     (Load_Data),
        .Instr         (Instr),
        .PC            (PC),
        .nPC           (nPC),
        .Fetch_Valid   (Fetch_Valid),
        .Branch_Pending(Branch_Pending),
        .Fetch_Count   (Fetch_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word at a byte address, from the model memory: the address is reduced
    // modulo the memory size and rounded down to a multiple of 4.
    function automatic logic [31:0] m_word(input logic [31:0] addr);
        int a;
        a = int'(addr % MEMB);
        a = a - (a % 4);
        return {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
    endfunction

    // One clock edge of the fetch rules.
    task automatic model_edge(input logic rst, input logic le, input logic bt,
                              input logic [31:0] tgt, input logic ld,
                              input logic [8:0] la, input logic [7:0] ldat);
        logic [31:0] redirect;
        logic        taken;
        if (ld) m_mem[la] = ldat;
        if (rst) begin
            m_pc = 32'h0; m_npc = 32'h4; m_pv = 1'b0; m_pt = 32'h0;
            m_fv = 1'b0; m_cnt = 32'h0;
        end else begin
            m_fv = 1'b1;
            if (le) begin
                taken    = bt || m_pv;
                redirect = bt ? tgt : m_pt;
                m_pc     = m_npc;
                m_npc    = taken ? redirect : m_npc + 32'd4;
                m_pv     = 1'b0;
                m_cnt    = m_cnt + 32'd1;
            end else if (bt) begin
                m_pv = 1'b1;
                m_pt = tgt;
            end
        end
    endtask

    task automatic compare_all();
        chk("pc",      PC,                    m_pc);
        chk("npc",     nPC,                   m_npc);
        chk("instr",   Instr,                 m_word(m_pc));
        chk("valid",   {31'b0, Fetch_Valid},  {31'b0, m_fv});
        chk("pending", {31'b0, Branch_Pending}, {31'b0, m_pv});
        chk("count",   Fetch_Count,           m_cnt);
    endtask

    task automatic step(input logic rst, input logic le, input logic bt,
                        input logic [31:0] tgt, input logic ld,
                        input logic [8:0] la, input logic [7:0] ldat);
        Reset = rst; LE = le; Branch_Taken = bt; Branch_Target = tgt;
        Load_En = ld; Load_Addr = la; Load_Data = ldat;
        @(posedge Clk);
        model_edge(rst, le, bt, tgt, ld, la, ldat);
        #1;
        compare_all();
    endtask

    // Shorthand for a plain cycle with no preload.
    task automatic run(input logic le, input logic bt, input logic [31:0] tgt);
        step(1'b0, le, bt, tgt, 1'b0, 9'd0, 8'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] tgt;
        Reset = 1'b1; LE = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
        Load_En = 1'b0; Load_Addr = 9'd0; Load_Data = 8'd0;

        // Preload the whole memory while held in reset; first three words fixed.
        for (int i = 0; i < MEMB; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < 4)       b = 8'h11;
            else if (i < 8)  b = 8'h22;
            else if (i < 12) b = 8'h33;
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 9'(i), b);
        end

        // Reset state and sequential fetch
        chk("rst_pc", PC, 32'h0);
        chk("rst_npc", nPC, 32'h4);
        chk("rst_instr", Instr, 32'h1111_1111);
        chk("rst_valid", {31'b0, Fetch_Valid}, 32'h0);
        chk("rst_count", Fetch_Count, 32'h0);
        run(1'b1, 1'b0, 32'h0);
        chk("seq_pc4", PC, 32'h4);
        chk("seq_instr4", Instr, 32'h2222_2222);
        chk("seq_valid", {31'b0, Fetch_Valid}, 32'h1);
        chk("seq_count1", Fetch_Count, 32'h1);

        // Delayed branch from PC=4 to 0x40
        run(1'b1, 1'b1, 32'h40);
        chk("br_pc8", PC, 32'h8);
        chk("br_npc40", nPC, 32'h40);
        chk("br_instr8", Instr, 32'h3333_3333);
        chk("br_count2", Fetch_Count, 32'h2);
        run(1'b1, 1'b0, 32'h0);
        chk("br_pc40", PC, 32'h40);
        run(1'b1, 1'b0, 32'h0);
        chk("br_pc44", PC, 32'h44);

        // Reach PC=0x10, then stall 3 cycles with a branch on stall cycle 2
        run(1'b1, 1'b1, 32'h10);
        run(1'b1, 1'b0, 32'h0);
        chk("st_pc10", PC, 32'h10);
        w = Fetch_Count;
        run(1'b0, 1'b0, 32'h0);
        run(1'b0, 1'b1, 32'h80);
        chk("st_pending", {31'b0, Branch_Pending}, 32'h1);
        run(1'b0, 1'b0, 32'h0);
        chk("st_hold_pc", PC, 32'h10);
        chk("st_hold_cnt", Fetch_Count, w);
        run(1'b1, 1'b0, 32'h0);
        chk("st_pc14", PC, 32'h14);
        chk("st_npc80", nPC, 32'h80);
        chk("st_pend_clr", {31'b0, Branch_Pending}, 32'h0);
        run(1'b1, 1'b0, 32'h0);
        chk("st_pc80", PC, 32'h80);

        // Override: park 0x80, release with a fresh request to 0xC0
        run(1'b0, 1'b1, 32'h80);
        run(1'b1, 1'b1, 32'hC0);
        chk("ov_pc84", PC, 32'h84);
        chk("ov_npcC0", nPC, 32'hC0);
        run(1'b1, 1'b0, 32'h0);
        chk("ov_pcC0", PC, 32'hC0);

        // Alias: 0x1FC -> 0x200 reads the word at 0
        run(1'b1, 1'b1, 32'h1FC);
        run(1'b1, 1'b0, 32'h0);
        chk("al_pc1fc", PC, 32'h1FC);
        run(1'b1, 1'b0, 32'h0);
        chk("al_pc200", PC, 32'h200);
        chk("al_instr", Instr, 32'h1111_1111);

        // 32-bit wrap: FFFF_FFFC -> 0
        run(1'b1, 1'b1, 32'hFFFF_FFF8);
        run(1'b1, 1'b0, 32'h0);
        run(1'b1, 1'b0, 32'h0);
        chk("wr_pcfffc", PC, 32'hFFFF_FFFC);
        chk("wr_npc0", nPC, 32'h0);
        run(1'b1, 1'b0, 32'h0);
        chk("wr_pc0", PC, 32'h0);

        // Reset during a stall with a branch pending, colliding with a new branch
        run(1'b0, 1'b1, 32'h100);
        chk("rp_pending", {31'b0, Branch_Pending}, 32'h1);
        step(1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 9'd0, 8'd0);
        chk("rp_pc", PC, 32'h0);
        chk("rp_pend_clr", {31'b0, Branch_Pending}, 32'h0);
        chk("rp_valid", {31'b0, Fetch_Valid}, 32'h0);
        chk("rp_count", Fetch_Count, 32'h0);
        run(1'b0, 1'b0, 32'h0);
        chk("rp_nobranch", nPC, 32'h4);

        // Preload the word at PC while stalled
        chk("pl_before", {24'h0, Instr[31:24]}, 32'h11);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 9'd0, 8'hAB);
        chk("pl_after", {24'h0, Instr[31:24]}, 32'hAB);
        chk("pl_pc", PC, 32'h0);
        // Write under reset still lands
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 9'd1, 8'hCD);
        chk("pl_rst", {24'h0, Instr[23:16]}, 32'hCD);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic rst, le, bt, ld;
            rst = ($urandom_range(0, 99) == 0);
            le  = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 5) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 15) == 0) ? $urandom : (32'($urandom_range(0, 1023)) << 2);
            step(rst, le, bt, tgt, ld, 9'($urandom_range(0, 511)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
